alu_cmd_driver: RTL and testbench

ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_cmd_fifo.sv | 45 ++++
 rtl/alu_cmd_driver.sv | 129 ++++++++++++
 tb/tb_alu_cmd_driver.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command driver: opcodes, FSM states and the buffered command record.
package alu_pkg;

  localparam logic [3:0] OpAdd    = 4'd0;
  localparam logic [3:0] OpSub    = 4'd1;
  localparam logic [3:0] OpAnd    = 4'd2;
  localparam logic [3:0] OpOr     = 4'd3;
  localparam logic [3:0] OpXor    = 4'd4;
  localparam logic [3:0] OpNot    = 4'd5;
  localparam logic [3:0] OpSelSum = 4'd6;
  localparam logic [3:0] OpAddRev = 4'd7;

  localparam int unsigned CmdWidth = 41;

  typedef enum logic [1:0] {
    StIdle,
    StDrive,
    StResp
  } state_e;

  typedef struct packed {
    logic [3:0] opcode;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic [7:0] d;
    logic       sel;
    logic [3:0] tag;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO; full/empty told apart by an extra pointer bit.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [CmdWidth-1:0] wdata,
  input  logic                pop,
  output logic [CmdWidth-1:0] rdata,
  output logic                full,
  output logic                empty
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW:0] PtrOne = 1;

  logic [CmdWidth-1:0] mem_q [FIFO_DEPTH];
  logic [PtrW:0]       wptr_q, rptr_q;
  logic                do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PtrW] != rptr_q[PtrW]) &&
                   (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem_q[rptr_q[PtrW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/alu_cmd_driver.sv
// Buffers ALU commands, drives them one at a time to an external combinational ALU and
// returns each result with its caller tag over a valid/ready response port.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [3:0]  cmd_opcode,
  input  logic [7:0]  cmd_a,
  input  logic [7:0]  cmd_b,
  input  logic [7:0]  cmd_c,
  input  logic [7:0]  cmd_d,
  input  logic        cmd_sel,
  input  logic [3:0]  cmd_tag,
  output logic [3:0]  alu_opcode,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [7:0]  alu_c,
  output logic [7:0]  alu_d,
  output logic        alu_sel,
  input  logic [7:0]  alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_result,
  output logic        rsp_zero,
  output logic [3:0]  rsp_tag,
  output logic        rsp_mismatch,
  output logic [15:0] zero_count,
  output logic        busy
);

  state_e              state_q, state_d;
  logic                fifo_full, fifo_empty;
  logic                pop, capture;
  logic [CmdWidth-1:0] push_bits, head_bits;
  cmd_t                issue_q;
  logic [7:0]          rsp_result_q;
  logic                rsp_zero_q, rsp_mismatch_q;
  logic [3:0]          rsp_tag_q;
  logic [15:0]         zero_count_q;

  // Held low during reset so no command is taken while the buffer is being cleared.
  assign cmd_ready = !fifo_full && !rst;
  assign push_bits = {cmd_opcode, cmd_a, cmd_b, cmd_c, cmd_d, cmd_sel, cmd_tag};

  alu_cmd_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (cmd_valid && cmd_ready),
    .wdata(push_bits),
    .pop  (pop),
    .rdata(head_bits),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (!fifo_empty) state_d = StDrive;
      StDrive: state_d = StResp;
      StResp:  if (rsp_ready) state_d = fifo_empty ? StIdle : StDrive;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    capture   = 1'b0;
    rsp_valid = 1'b0;
    unique case (state_q)
      StIdle:  pop = !fifo_empty;
      StDrive: capture = 1'b1;
      StResp: begin
        rsp_valid = 1'b1;
        pop       = rsp_ready && !fifo_empty;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_q        <= '0;
      rsp_result_q   <= '0;
      rsp_zero_q     <= 1'b0;
      rsp_tag_q      <= '0;
      rsp_mismatch_q <= 1'b0;
      zero_count_q   <= '0;
    end else begin
      if (pop) issue_q <= cmd_t'(head_bits);
      if (capture) begin
        rsp_result_q   <= alu_result;
        rsp_zero_q     <= alu_zero;
        rsp_tag_q      <= issue_q.tag;
        rsp_mismatch_q <= alu_zero != (alu_result == 8'h00);
      end
      if (rsp_valid && rsp_ready && rsp_zero_q && zero_count_q != 16'hFFFF) begin
        zero_count_q <= zero_count_q + 16'd1;
      end
    end
  end

  assign alu_opcode   = issue_q.opcode;
  assign alu_a        = issue_q.a;
  assign alu_b        = issue_q.b;
  assign alu_c        = issue_q.c;
  assign alu_d        = issue_q.d;
  assign alu_sel      = issue_q.sel;
  assign rsp_result   = rsp_result_q;
  assign rsp_zero     = rsp_zero_q;
  assign rsp_tag      = rsp_tag_q;
  assign rsp_mismatch = rsp_mismatch_q;
  assign zero_count   = zero_count_q;
  assign busy         = (state_q != StIdle) || !fifo_empty;

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Directed bench for alu_cmd_driver with a behavioural 8-bit ALU and an in-order response scoreboard.
module tb_alu_cmd_driver;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_sel;
  logic [3:0]  cmd_opcode, cmd_tag;
  logic [7:0]  cmd_a, cmd_b, cmd_c, cmd_d;
  logic [3:0]  alu_opcode;
  logic [7:0]  alu_a, alu_b, alu_c, alu_d, alu_result;
  logic        alu_sel, alu_zero;
  logic        rsp_valid, rsp_ready, rsp_zero, rsp_mismatch, busy;
  logic [7:0]  rsp_result;
  logic [3:0]  rsp_tag;
  logic [15:0] zero_count;
  logic        bad_zero;

  typedef struct {
    logic [7:0] res;
    logic       zero;
    logic       mm;
    logic [3:0] tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   exp_zc = 0;

  always #5 clk = ~clk;

  alu_cmd_driver #(
    .FIFO_DEPTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_opcode  (cmd_opcode),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .cmd_c       (cmd_c),
    .cmd_d       (cmd_d),
    .cmd_sel     (cmd_sel),
    .cmd_tag     (cmd_tag),
    .alu_opcode  (alu_opcode),
    .alu_a       (alu_a),
    .alu_b       (alu_b),
    .alu_c       (alu_c),
    .alu_d       (alu_d),
    .alu_sel     (alu_sel),
    .alu_result  (alu_result),
    .alu_zero    (alu_zero),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_result  (rsp_result),
    .rsp_zero    (rsp_zero),
    .rsp_tag     (rsp_tag),
    .rsp_mismatch(rsp_mismatch),
    .zero_count  (zero_count),
    .busy        (busy)
  );

  function automatic logic [7:0] alu_fn(input logic [3:0] op, input logic [7:0] a, b, c, d,
                                        input logic sel);
    case (op)
      OpAdd:    return a + b + c + d;
      OpSub:    return a - b;
      OpAnd:    return a & b;
      OpOr:     return a | b;
      OpXor:    return a ^ b;
      OpNot:    return ~a;
      OpSelSum: return sel ? a + c : b + d;
      OpAddRev: return d + c;
      default:  return 8'h00;
    endcase
  endfunction

  // Stand-in for the team ALU; bad_zero forces a wrong zero flag.
  always_comb begin
    alu_result = alu_fn(alu_opcode, alu_a, alu_b, alu_c, alu_d, alu_sel);
    alu_zero   = bad_zero ? 1'b0 : (alu_result == 8'h00);
  end

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  task automatic send(input logic [3:0] op, input logic [7:0] a, b, c, d, input logic sel,
                      input logic [3:0] tag);
    exp_t       e;
    int         n;
    logic [7:0] r;
    cmd_opcode = op;
    cmd_a      = a;
    cmd_b      = b;
    cmd_c      = c;
    cmd_d      = d;
    cmd_sel    = sel;
    cmd_tag    = tag;
    cmd_valid  = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("cmd_accept_wait", 32'(n < 50), 32'd1);
    r      = alu_fn(op, a, b, c, d, sel);
    e.res  = r;
    e.zero = bad_zero ? 1'b0 : (r == 8'h00);
    e.mm   = bad_zero && (r == 8'h00);
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || busy) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_wait", 32'(n < 200), 32'd1);
  endtask

  // Every accepted response must match the oldest outstanding command.
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      chk("rsp_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("rsp_tag", 32'(rsp_tag), 32'(mon_e.tag));
        chk("rsp_result", 32'(rsp_result), 32'(mon_e.res));
        chk("rsp_zero", 32'(rsp_zero), 32'(mon_e.zero));
        chk("rsp_mismatch", 32'(rsp_mismatch), 32'(mon_e.mm));
        if (mon_e.zero) exp_zc++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    cmd_valid  = 1'b0;
    cmd_opcode = '0;
    cmd_a      = '0;
    cmd_b      = '0;
    cmd_c      = '0;
    cmd_d      = '0;
    cmd_sel    = 1'b0;
    cmd_tag    = '0;
    rsp_ready  = 1'b0;
    bad_zero   = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_zero_count", 32'(zero_count), 32'd0);
    chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
    rst = 1'b0;
    #1;
    chk("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // Latency: handshake at E0, response visible after E2.
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    send(OpAdd, 8'h10, 8'h20, 8'h30, 8'h40, 1'b0, 4'd3);
    chk("lat_e0_valid", 32'(rsp_valid), 32'd0);
    chk("lat_e0_busy", 32'(busy), 32'd1);
    @(posedge clk);
    #1;
    chk("lat_e1_valid", 32'(rsp_valid), 32'd0);
    chk("issue_opcode", 32'(alu_opcode), 32'(OpAdd));
    chk("issue_a", 32'(alu_a), 32'h10);
    @(posedge clk);
    #1;
    chk("lat_e2_valid", 32'(rsp_valid), 32'd1);
    chk("add_result", 32'(rsp_result), 32'hA0);
    chk("add_tag", 32'(rsp_tag), 32'd3);
    @(posedge clk);
    #1;
    chk("rsp_valid_drop", 32'(rsp_valid), 32'd0);
    chk("alu_d_hold", 32'(alu_d), 32'h40);
    chk("zero_count_add", 32'(zero_count), 32'd0);

    // Two zero results back to back.
    send(OpSub, 8'h05, 8'h05, 8'h00, 8'h00, 1'b0, 4'd4);
    send(OpSelSum, 8'hFF, 8'h00, 8'h01, 8'h00, 1'b1, 4'd5);
    drain();
    chk("zero_count_two", 32'(zero_count), 32'd2);

    // Backpressure: fill the buffer while the first response is held.
    rsp_ready = 1'b0;
    send(OpAnd, 8'hF3, 8'h3C, 8'h00, 8'h00, 1'b0, 4'd1);
    send(OpOr, 8'h01, 8'h80, 8'h00, 8'h00, 1'b0, 4'd2);
    send(OpXor, 8'hAA, 8'h55, 8'h00, 8'h00, 1'b0, 4'd3);
    chk("ready_before_full", 32'(cmd_ready), 32'd1);
    send(OpNot, 8'h0F, 8'h00, 8'h00, 8'h00, 1'b0, 4'd4);
    send(OpAddRev, 8'h00, 8'h00, 8'h12, 8'h34, 1'b0, 4'd5);
    chk("full_ready_low", 32'(cmd_ready), 32'd0);
    chk("full_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("full_rsp_tag", 32'(rsp_tag), 32'd1);
    // Offer an extra command that must be refused, including on the popping edge.
    cmd_opcode = OpAdd;
    cmd_tag    = 4'hF;
    cmd_valid  = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("full_hold_ready", 32'(cmd_ready), 32'd0);
    chk("full_hold_tag", 32'(rsp_tag), 32'd1);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    drain();
    chk("zero_count_bp", 32'(zero_count), 32'(exp_zc));

    // Undefined opcode: ALU returns zero; then a lying zero flag.
    send(4'hC, 8'hAA, 8'h00, 8'h00, 8'h00, 1'b0, 4'd6);
    drain();
    bad_zero = 1'b1;
    send(4'hC, 8'hAA, 8'h00, 8'h00, 8'h00, 1'b0, 4'd7);
    drain();
    bad_zero = 1'b0;
    chk("zero_count_opc", 32'(zero_count), 32'(exp_zc));

    // Reset while driving with two commands buffered.
    rsp_ready = 1'b0;
    send(OpAdd, 8'h01, 8'h01, 8'h01, 8'h01, 1'b0, 4'd8);
    send(OpAdd, 8'h02, 8'h02, 8'h02, 8'h02, 1'b0, 4'd9);
    send(OpAdd, 8'h03, 8'h03, 8'h03, 8'h03, 1'b0, 4'd10);
    rsp_ready = 1'b1;
    send(OpAdd, 8'h04, 8'h04, 8'h04, 8'h04, 1'b0, 4'd11);
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_drive_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b1;
    sb.delete();
    exp_zc = 0;
    #1;
    chk("mid_rst_ready", 32'(cmd_ready), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_alu_a", 32'(alu_a), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    chk("after_rst_valid", 32'(rsp_valid), 32'd0);
    chk("after_rst_busy", 32'(busy), 32'd0);
    chk("after_rst_zero_count", 32'(zero_count), 32'd0);

    send(OpAdd, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0, 4'd12);
    drain();
    chk("final_zero_count", 32'(zero_count), 32'(exp_zc));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
